// File: rtl/uart_stream_arb_pkg.sv
// Shared state type, default pad byte and round-robin helper for the UART stream arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, PASS, ABORT} arb_state_t;

  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h00;

  // Scans ptr+1, ptr+2, ... modulo num (2..16) and returns the first requester seen.
  function automatic logic [3:0] next_rr(input logic [15:0] req, input logic [3:0] ptr,
                                         input int num);
    logic [3:0] win;
    int         cand;
    win = ptr;
    for (int k = 16; k >= 1; k--) begin
      if (k <= num) begin
        cand = int'(ptr) + k;
        if (cand >= num) cand = cand - num;
        if (req[cand[3:0]]) win = cand[3:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_stream_arb_rr_pick.sv
// Combinational priority rotator: lowest-distance requester after ptr wins.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] ptr,
  output logic [$clog2(NUM_IN)-1:0] idx,
  output logic                      any
);

  localparam int PW = $clog2(NUM_IN);

  logic [3:0] win;

  always_comb begin
    win = next_rr(16'(req), 4'(ptr), NUM_IN);
  end

  assign idx = PW'(win);
  assign any = |req;

endmodule

// File: rtl/uart_stream_arb.sv
// Packet-atomic round-robin arbiter merging NUM_IN byte streams onto the host UART stream.
// A granted source that stalls too long is cut off with a pad byte carrying eop.
module uart_stream_arb
  import uart_arb_pkg::*;
#(
  parameter int         NUM_IN      = 4,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [7:0] PAD_BYTE    = DEFAULT_PAD_BYTE
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_IN*8-1:0]       i_axi_dat,
  input  logic [NUM_IN-1:0]         i_axi_val,
  input  logic [NUM_IN-1:0]         i_axi_sop,
  input  logic [NUM_IN-1:0]         i_axi_eop,
  output logic [NUM_IN-1:0]         i_axi_rdy,
  output logic [7:0]                o_axi_dat,
  output logic                      o_axi_val,
  output logic                      o_axi_sop,
  output logic                      o_axi_eop,
  input  logic                      o_axi_rdy,
  output logic [NUM_IN-1:0]         o_grant,
  output logic                      o_timeout,
  output logic                      o_err_sop,
  output logic [$clog2(NUM_IN)-1:0] o_abort_src
);

  localparam int          PW         = $clog2(NUM_IN);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [15:0] CNT_LIMIT  = 16'(TIMEOUT_CYC - 1);

  arb_state_t        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [NUM_IN-1:0] pick_onehot;
  logic [15:0]       idle_cnt;
  logic              first_beat;
  logic              slice_free;
  logic              accept;
  logic              g_val;
  logic              g_sop;
  logic              g_eop;
  logic [7:0]        g_dat;

  rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req (i_axi_val),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign slice_free = ~o_axi_val | o_axi_rdy;
  assign g_val      = i_axi_val[gidx];
  assign g_sop      = i_axi_sop[gidx];
  assign g_eop      = i_axi_eop[gidx];
  assign g_dat      = i_axi_dat[gidx*8 +: 8];
  assign accept     = (state == PASS) && g_val && slice_free;
  assign i_axi_rdy  = ((state == PASS) && slice_free) ? o_grant : '0;

  // Only a granted source with val low ages the stall counter; back-pressure never does.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rr_ptr      <= PW'(NUM_IN - 1);
      gidx        <= '0;
      idle_cnt    <= '0;
      first_beat  <= 1'b0;
      o_axi_dat   <= '0;
      o_axi_val   <= 1'b0;
      o_axi_sop   <= 1'b0;
      o_axi_eop   <= 1'b0;
      o_grant     <= '0;
      o_timeout   <= 1'b0;
      o_err_sop   <= 1'b0;
      o_abort_src <= '0;
    end else begin
      o_timeout <= 1'b0;
      if (slice_free) o_axi_val <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            o_grant    <= pick_onehot;
            rr_ptr     <= pick_idx;
            gidx       <= pick_idx;
            idle_cnt   <= '0;
            first_beat <= 1'b1;
            state      <= PASS;
          end
        end
        PASS: begin
          if (accept) begin
            o_axi_dat  <= g_dat;
            o_axi_sop  <= g_sop;
            o_axi_eop  <= g_eop;
            o_axi_val  <= 1'b1;
            idle_cnt   <= '0;
            first_beat <= 1'b0;
            if (first_beat && !g_sop) o_err_sop <= 1'b1;
            if (g_eop) begin
              o_grant <= '0;
              state   <= IDLE;
            end
          end else if (!g_val) begin
            if (TIMEOUT_EN && (idle_cnt == CNT_LIMIT)) state <= ABORT;
            else if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
          end
        end
        ABORT: begin
          if (slice_free) begin
            o_axi_dat   <= PAD_BYTE;
            o_axi_sop   <= 1'b0;
            o_axi_eop   <= 1'b1;
            o_axi_val   <= 1'b1;
            o_timeout   <= 1'b1;
            o_abort_src <= gidx;
            o_grant     <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_arb.sv
// Scoreboard bench for uart_stream_arb: per-source beat queues feed the DUT, expected
// output beats are queued as stimulus is planned and popped as the merged stream delivers.
module tb_uart_stream_arb;

  localparam int NUM_IN      = 4;
  localparam int TIMEOUT_CYC = 8;

  typedef struct packed {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
  } beat_t;

  logic                clk;
  logic                i_rst_n;
  logic [NUM_IN*8-1:0] i_axi_dat;
  logic [NUM_IN-1:0]   i_axi_val;
  logic [NUM_IN-1:0]   i_axi_sop;
  logic [NUM_IN-1:0]   i_axi_eop;
  logic [NUM_IN-1:0]   i_axi_rdy;
  logic [7:0]          o_axi_dat;
  logic                o_axi_val;
  logic                o_axi_sop;
  logic                o_axi_eop;
  logic                o_axi_rdy;
  logic [NUM_IN-1:0]   o_grant;
  logic                o_timeout;
  logic                o_err_sop;
  logic [1:0]          o_abort_src;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t             src_q[NUM_IN][$];
  beat_t             exp_q[$];
  logic [NUM_IN-1:0] grant_log[$];
  bit                fired[NUM_IN];
  int                sent[NUM_IN];
  int                sink_mode      = 0;
  int                timeout_pulses = 0;
  int                timeout_cyc    = 0;
  int                last_fire1     = 0;
  int                no_bubble      = 0;
  logic              prev_in_fire;
  logic [7:0]        prev_in_dat;
  logic [NUM_IN-1:0] prev_grant;

  uart_stream_arb #(
    .NUM_IN      (NUM_IN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .PAD_BYTE    (8'h00)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_axi_dat   (i_axi_dat),
    .i_axi_val   (i_axi_val),
    .i_axi_sop   (i_axi_sop),
    .i_axi_eop   (i_axi_eop),
    .i_axi_rdy   (i_axi_rdy),
    .o_axi_dat   (o_axi_dat),
    .o_axi_val   (o_axi_val),
    .o_axi_sop   (o_axi_sop),
    .o_axi_eop   (o_axi_eop),
    .o_axi_rdy   (o_axi_rdy),
    .o_grant     (o_grant),
    .o_timeout   (o_timeout),
    .o_err_sop   (o_err_sop),
    .o_abort_src (o_abort_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives sources and sink on the falling edge, samples handshakes just before the rising edge.
  initial begin
    beat_t      b;
    beat_t      e;
    logic       in_fire;
    logic [7:0] in_dat;
    i_axi_dat    = '0;
    i_axi_val    = '0;
    i_axi_sop    = '0;
    i_axi_eop    = '0;
    o_axi_rdy    = 1'b1;
    prev_in_fire = 1'b0;
    prev_in_dat  = '0;
    prev_grant   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      fired[i] = 1'b0;
      sent[i]  = 0;
    end
    forever begin
      @(negedge clk);
      case (sink_mode)
        0:       o_axi_rdy = 1'b1;
        1:       o_axi_rdy = ~o_axi_rdy;
        default: o_axi_rdy = 1'b0;
      endcase
      for (int i = 0; i < NUM_IN; i++) begin
        if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        fired[i] = 1'b0;
        if (i_rst_n && src_q[i].size() > 0) begin
          b                  = src_q[i][0];
          i_axi_val[i]       = 1'b1;
          i_axi_dat[i*8 +: 8] = b.dat;
          i_axi_sop[i]       = b.sop;
          i_axi_eop[i]       = b.eop;
        end else begin
          i_axi_val[i] = 1'b0;
          i_axi_sop[i] = 1'b0;
          i_axi_eop[i] = 1'b0;
        end
      end
      #4;
      cyc++;
      if (!i_rst_n) begin
        prev_in_fire = 1'b0;
        prev_grant   = '0;
      end else begin
        in_fire = 1'b0;
        in_dat  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
          if (i_axi_val[i] && i_axi_rdy[i]) begin
            fired[i] = 1'b1;
            sent[i]++;
            in_fire = 1'b1;
            in_dat  = i_axi_dat[i*8 +: 8];
            if (i == 1) last_fire1 = cyc;
          end
        end
        if (prev_in_fire) begin
          total++;
          if ({o_axi_val, o_axi_dat} !== {1'b1, prev_in_dat}) begin
            bad++;
            $display("[TB] FAIL latency: out val/dat=%b/%h, required 1/%h", o_axi_val, o_axi_dat, prev_in_dat);
          end
        end
        if (o_axi_val && !o_axi_rdy) begin
          total++;
          if (i_axi_rdy !== '0) begin
            bad++;
            $display("[TB] FAIL stall_rdy: i_axi_rdy=%b while slice full, required 0", i_axi_rdy);
          end
        end
        if (o_axi_val && o_axi_rdy) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_beat: got dat=%h sop=%b eop=%b, required none", o_axi_dat, o_axi_sop, o_axi_eop);
          end else begin
            e = exp_q.pop_front();
            if ({o_axi_dat, o_axi_sop, o_axi_eop} !== e) begin
              bad++;
              $display("[TB] FAIL beat: got dat=%h sop=%b eop=%b, required dat=%h sop=%b eop=%b",
                       o_axi_dat, o_axi_sop, o_axi_eop, e.dat, e.sop, e.eop);
            end
          end
        end
        if (o_timeout) begin
          timeout_pulses++;
          timeout_cyc = cyc;
        end
        if (o_grant != prev_grant) begin
          if (o_grant != '0) grant_log.push_back(o_grant);
          if (prev_grant != '0 && o_grant != '0) no_bubble++;
        end
        prev_grant   = o_grant;
        prev_in_fire = in_fire;
        prev_in_dat  = in_dat;
      end
    end
  end

  task automatic drive_beat(input int s, input logic [7:0] d, input logic sop, input logic eop);
    beat_t b;
    b.dat = d;
    b.sop = sop;
    b.eop = eop;
    src_q[s].push_back(b);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic sop, input logic eop);
    beat_t b;
    b.dat = d;
    b.sop = sop;
    b.eop = eop;
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    i_rst_n   = 1'b0;
    sink_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({o_axi_val, o_axi_sop, o_axi_eop, o_axi_dat} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset_out: val/sop/eop/dat=%b/%b/%b/%h, required 0/0/0/00", o_axi_val, o_axi_sop, o_axi_eop, o_axi_dat);
    end
    total++;
    if (o_grant !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_grant: got %b, required 0000", o_grant);
    end
    total++;
    if ({o_timeout, o_err_sop, o_abort_src} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_status: timeout/err_sop/abort_src=%b/%b/%0d, required 0/0/0", o_timeout, o_err_sop, o_abort_src);
    end
    total++;
    if (i_axi_rdy !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_rdy: got %b, required 0000", i_axi_rdy);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int               srcs[3] = '{0, 1, 3};
    logic [7:0]       d;
    logic [NUM_IN-1:0] g_exp;
    grant_log.delete();
    no_bubble = 0;
    for (int p = 0; p < 2; p++) begin
      for (int si = 0; si < 3; si++) begin
        for (int b = 0; b < 3; b++) begin
          d = 8'(srcs[si] * 32 + p * 8 + b + 1);
          drive_beat(srcs[si], d, b == 0, b == 2);
          expect_beat(d, b == 0, b == 2);
        end
      end
    end
    wait_drain(300);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rr_drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (grant_log.size() != 6) begin
      bad++;
      $display("[TB] FAIL rr_grant_count: got %0d grants, required 6", grant_log.size());
    end
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) begin
        g_exp = 4'(1 << srcs[k % 3]);
        total++;
        if (grant_log[k] !== g_exp) begin
          bad++;
          $display("[TB] FAIL rr_order[%0d]: got %b, required %b", k, grant_log[k], g_exp);
        end
      end
    end
    total++;
    if (no_bubble != 0) begin
      bad++;
      $display("[TB] FAIL rr_bubble: %0d direct grant switches, required 0", no_bubble);
    end
  endtask

  task automatic test_single_source();
    logic [7:0] pkt[5] = '{8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    @(posedge clk);
    #2;
    total++;
    if (o_grant !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL single_idle: grant=%b, required 0000", o_grant);
    end
    for (int b = 0; b < 5; b++) begin
      drive_beat(2, pkt[b], b == 0, b == 4);
      expect_beat(pkt[b], b == 0, b == 4);
    end
    @(posedge clk);
    #2;
    total++;
    if (o_grant !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL single_grant: grant=%b, required 0100", o_grant);
    end
    wait_drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL single_drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (o_grant !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL single_after: grant=%b, required 0000", o_grant);
    end
  endtask

  task automatic test_back_pressure();
    int t0;
    int base;
    t0        = timeout_pulses;
    base      = sent[2];
    sink_mode = 1;
    for (int b = 0; b < 4; b++) begin
      drive_beat(2, 8'(8'hB1 + b), b == 0, b == 3);
      expect_beat(8'(8'hB1 + b), b == 0, b == 3);
    end
    for (int c = 0; c < 100 && sent[2] < base + 2; c++) @(posedge clk);
    #2;
    sink_mode = 2;
    repeat (12) @(posedge clk);
    #2;
    sink_mode = 1;
    wait_drain(100);
    sink_mode = 0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL bp_drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (timeout_pulses != t0) begin
      bad++;
      $display("[TB] FAIL bp_timeout: %0d timeout pulses, required 0", timeout_pulses - t0);
    end
  endtask

  task automatic test_timeout();
    int t0;
    t0 = timeout_pulses;
    grant_log.delete();
    drive_beat(1, 8'h61, 1'b1, 1'b0);
    drive_beat(1, 8'h62, 1'b0, 1'b0);
    expect_beat(8'h61, 1'b1, 1'b0);
    expect_beat(8'h62, 1'b0, 1'b0);
    expect_beat(8'h00, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) expect_beat(8'(8'h71 + b), b == 0, b == 2);
    for (int c = 0; c < 100 && src_q[1].size() != 0; c++) @(posedge clk);
    #2;
    for (int b = 0; b < 3; b++) drive_beat(0, 8'(8'h71 + b), b == 0, b == 2);
    wait_drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL to_drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (timeout_pulses - t0 != 1) begin
      bad++;
      $display("[TB] FAIL to_pulses: got %0d, required 1", timeout_pulses - t0);
    end
    total++;
    if (timeout_cyc - last_fire1 != TIMEOUT_CYC + 2) begin
      bad++;
      $display("[TB] FAIL to_delay: pulse %0d cycles after last beat, required %0d", timeout_cyc - last_fire1, TIMEOUT_CYC + 2);
    end
    total++;
    if (o_abort_src !== 2'd1) begin
      bad++;
      $display("[TB] FAIL to_src: got %0d, required 1", o_abort_src);
    end
    total++;
    if (grant_log.size() != 2 || grant_log[0] !== 4'b0010 || grant_log[1] !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL to_grants: got %0d grants first=%b, required 0010 then 0001",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 4'b0000);
    end
    total++;
    if (o_err_sop !== 1'b0) begin
      bad++;
      $display("[TB] FAIL to_err_sop: got %b, required 0", o_err_sop);
    end
  endtask

  task automatic test_sop_error();
    drive_beat(0, 8'h41, 1'b0, 1'b0);
    drive_beat(0, 8'h42, 1'b0, 1'b0);
    drive_beat(0, 8'h43, 1'b0, 1'b1);
    expect_beat(8'h41, 1'b0, 1'b0);
    expect_beat(8'h42, 1'b0, 1'b0);
    expect_beat(8'h43, 1'b0, 1'b1);
    wait_drain(100);
    total++;
    if (o_err_sop !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sop_set: err_sop=%b, required 1", o_err_sop);
    end
    drive_beat(0, 8'h44, 1'b1, 1'b0);
    drive_beat(0, 8'h45, 1'b0, 1'b1);
    expect_beat(8'h44, 1'b1, 1'b0);
    expect_beat(8'h45, 1'b0, 1'b1);
    wait_drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL sop_drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (o_err_sop !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sop_sticky: err_sop=%b, required 1", o_err_sop);
    end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    base = sent[3];
    for (int b = 0; b < 5; b++) begin
      drive_beat(3, 8'(8'h81 + b), b == 0, b == 4);
      expect_beat(8'(8'h81 + b), b == 0, b == 4);
    end
    for (int c = 0; c < 100 && sent[3] < base + 2; c++) @(posedge clk);
    #2;
    i_rst_n = 1'b0;
    src_q[3].delete();
    @(posedge clk);
    #2;
    exp_q.delete();
    grant_log.delete();
    total++;
    if ({o_axi_val, o_grant} !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL rst_mid: val=%b grant=%b, required 0 and 0000", o_axi_val, o_grant);
    end
    total++;
    if (o_err_sop !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_err_sop: got %b, required 0", o_err_sop);
    end
    i_rst_n = 1'b1;
    drive_beat(0, 8'h91, 1'b1, 1'b1);
    drive_beat(3, 8'hA1, 1'b1, 1'b1);
    expect_beat(8'h91, 1'b1, 1'b1);
    expect_beat(8'hA1, 1'b1, 1'b1);
    wait_drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rst_drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (grant_log.size() != 2 || grant_log[0] !== 4'b0001 || grant_log[1] !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL rst_contention: got %0d grants first=%b, required 0001 then 1000",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 4'b0000);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_single_source();
    test_back_pressure();
    test_timeout();
    test_sop_error();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_stream_arb.md
Name: uart_stream_arb

Overview:
- Packet-atomic round-robin arbiter that shares the single FPGA-to-host UART stream between NUM_IN requesters.
- Sits in front of uart_wrapper's rx_if, which carries data towards the host.
- A grant is held from sop to eop so length-prefixed packets are never interleaved.
- A stalled requester is cut off after a timeout: the block injects a pad byte with eop so uart_wrapper can return to its wait state.

Parameters:
- NUM_IN, 4, number of requesters (2..16).
- TIMEOUT_CYC, 1024, consecutive cycles with val low from the granted source before abort; 0 disables the timeout.
- PAD_BYTE, 8'h00, data byte injected on abort.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  synchronous reset, active low.
- i_axi  if_axi_stream.sink  [NUM_IN] x (DAT_BYTS=1)  requester streams (dat, val, rdy, sop, eop).
- o_axi  if_axi_stream.source  DAT_BYTS=1  merged stream; connects to uart_wrapper rx_if.
- o_grant  output  NUM_IN  one-hot current grant; all zero when idle.
- o_timeout  output  1  single-cycle pulse when an abort is issued.
- o_err_sop  output  1  sticky; set when the first beat accepted under a new grant lacks sop.
- o_abort_src  output  $clog2(NUM_IN)  index of the source that was last aborted.

Behaviour:
- Reset (i_rst_n=0 at posedge) values:
  - o_axi: val=0, sop=0, eop=0, dat=0.
  - o_grant=0, o_timeout=0, o_err_sop=0, o_abort_src=0.
  - All i_axi[i].rdy=0.
  - State=IDLE, rr_ptr=NUM_IN-1, so input 0 has first priority.
  - Reset mid-packet drops the packet; no eop is emitted.
- Output register slice: o_axi is registered.
  - It loads when ~o_axi.val || o_axi.rdy.
  - Latency from input accept to o_axi.val is 1 cycle.
  - Full throughput of 1 beat/cycle is sustained when o_axi.rdy=1.
- i_axi[g].rdy = (state==PASS) && o_grant[g] && (~o_axi.val || o_axi.rdy). It is combinational from state/grant and the output slice. All non-granted rdy=0.
- States:
  - IDLE:
    - If any i_axi[i].val, pick the first requester with val=1 scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
    - Register o_grant to that requester and set rr_ptr to its index.
    - Go to PASS. Arbitration costs 1 cycle.
  - PASS:
    - Forward accepted beats (dat/sop/eop copied).
    - On an accepted beat with eop=1: o_grant<=0, go to IDLE. This leaves a one-cycle bubble between packets.
    - Requests arriving in the same cycle as eop are arbitrated in the following IDLE cycle.
  - ABORT:
    - Load o_axi with dat=PAD_BYTE, sop=0, eop=1 once the slice is free.
    - Pulse o_timeout and set o_abort_src=grant index.
    - Set o_grant<=0 and go to IDLE.
- Timeout counter (16 bits, saturating):
  - Cleared on entry to PASS and on every accepted beat.
  - Increments each PASS cycle where the granted val=0.
  - Back-pressure (val=1, rdy=0) does not count.
  - When TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 with val still 0, go to ABORT.
  - If val rises in the same cycle the counter reaches threshold, the beat wins: no abort.
- Sop check:
  - The first accepted beat after each grant must have sop=1; otherwise o_err_sop<=1 and the beat is forwarded unchanged.
  - o_err_sop clears only on reset.
- The aborted source is not penalised. It re-competes normally, and its remaining beats are forwarded as a new (sop-less) packet, which sets o_err_sop.
- Single-beat packet (sop=eop=1) is legal.
- With NUM_IN requesters continuously requesting, each is granted once every NUM_IN packets.

Decomposition:
- Package uart_arb_pkg holds:
  - arb_state_t enum {IDLE, PASS, ABORT}.
  - Default PAD_BYTE constant.
  - Function next_rr(req, ptr) returning the winning index.
- One sub-module, rr_pick: combinational priority rotator.
  - Inputs: req[NUM_IN], ptr.
  - Outputs: idx, any.
  - Instantiated once in the top.

Test Plan:
- Single-source packet:
  - Stimulus: input 2 sends a 5-byte packet 05 00 AA BB CC, o_axi.rdy=1.
  - Required: o_grant=4'b0100 one cycle after val; bytes appear on o_axi 1 cycle after each accept, sop on 05, eop on CC; IDLE afterwards.
- Round robin:
  - Stimulus: inputs 0,1,3 each hold back-to-back 3-byte packets.
  - Required: grant order 0,1,3,0,1,3; never interleaved mid-packet; one idle cycle between packets.
- Back-pressure:
  - Stimulus: o_axi.rdy toggles 1010... during a 4-byte packet.
  - Required: no beat lost or duplicated; i_axi.rdy low whenever the slice is full and o_axi.rdy=0; timeout counter does not advance.
- Timeout abort:
  - Stimulus: TIMEOUT_CYC=8; input 1 sends 2 of 6 bytes then drops val.
  - Required: after 8 idle cycles, o_axi emits 00 with eop=1; o_timeout pulses once; o_abort_src=1; input 0 is then granted if requesting.
- Sop error:
  - Stimulus: input 0 starts a packet with sop=0.
  - Required: o_err_sop set and stays 1 across later good packets; data is forwarded unchanged.
- Reset mid-packet:
  - Stimulus: i_rst_n=0 for 1 cycle during byte 3 of a packet from input 3.
  - Required: next cycle o_axi.val=0 and o_grant=0; input 0 wins the next contention against input 3.
